// File: rtl/typedef_pkg.sv
// rtl/typedef_pkg.sv - shared vector opcode constants and issue-queue entry type
package typedef_pkg;

    localparam logic [6:0] v_arith_opcode = 7'b1010111;
    localparam logic [6:0] v_ld_opcode    = 7'b0000111;
    localparam logic [6:0] v_st_opcode    = 7'b0100111;
    localparam logic [2:0] OPCFG          = 3'b111;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } viq_entry_t;

endpackage

// File: rtl/viq_fence_chk.sv
// rtl/viq_fence_chk.sv - decodes whether the queue head is a vset* config instruction
module viq_fence_chk
    import typedef_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic       head_is_cfg
);

    // vset* shares the arith opcode and is distinguished by funct3
    assign head_is_cfg = (opcode == v_arith_opcode) && (funct3 == OPCFG);

endmodule

// File: rtl/vector_issue_queue.sv
// rtl/vector_issue_queue.sv - in-order FIFO between scalar core and vector scheduler with config fence
module vector_issue_queue
    import typedef_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_vld_i,
    input  logic [31:0]      vector_instr_i,
    input  logic [31:0]      rs1_i,
    input  logic [31:0]      rs2_i,
    output logic             vector_stall_o,
    output logic [31:0]      sched_instr_o,
    output logic [31:0]      sched_rs1_o,
    output logic [31:0]      sched_rs2_o,
    output logic             sched_vld_o,
    input  logic             sched_rdy_i,
    input  logic             vu_idle_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    viq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    viq_entry_t       head;
    logic             head_is_cfg;
    logic             push;
    logic             pop;

    assign head = mem[rd_ptr];

    viq_fence_chk u_fence_chk (
        .opcode      (head.instr[6:0]),
        .funct3      (head.instr[14:12]),
        .head_is_cfg (head_is_cfg)
    );

    // Stall and offer are derived from registered state, so a push into an
    // empty queue is only visible one cycle later and a pop never frees a slot
    // for a push in the same cycle.
    assign empty_o        = (count == '0);
    assign vector_stall_o = (count == CNT_W'(DEPTH));
    assign count_o        = count;
    assign sched_vld_o    = !empty_o && (!head_is_cfg || vu_idle_i);
    assign sched_instr_o  = sched_vld_o ? head.instr : 32'h0;
    assign sched_rs1_o    = sched_vld_o ? head.rs1   : 32'h0;
    assign sched_rs2_o    = sched_vld_o ? head.rs2   : 32'h0;

    assign push = instr_vld_i && !vector_stall_o;
    assign pop  = sched_vld_o && sched_rdy_i;

    // Entry storage; not reset, and a push coinciding with flush/reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push) begin
            mem[wr_ptr] <= '{instr: vector_instr_i, rs1: rs1_i, rs2: rs2_i};
        end
    end

    // Pointers and occupancy; flush shares the reset path and overrides push/pop
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Occupancy invariants: never pop empty, never push full, never exceed DEPTH
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(pop && empty_o));
            assert (!(push && vector_stall_o));
            assert (count <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_vector_issue_queue.sv
// tb/tb_vector_issue_queue.sv - directed table-driven bench for vector_issue_queue
module tb_vector_issue_queue;

    localparam logic [31:0] CFG = 32'h0C00_7057;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_vld_i;
    logic [31:0] vector_instr_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        vector_stall_o;
    logic [31:0] sched_instr_o;
    logic [31:0] sched_rs1_o;
    logic [31:0] sched_rs2_o;
    logic        sched_vld_o;
    logic        sched_rdy_i;
    logic        vu_idle_i;
    logic        flush_i;
    logic [2:0]  count_o;
    logic        empty_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vector_issue_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_vld_i    (instr_vld_i),
        .vector_instr_i (vector_instr_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .vector_stall_o (vector_stall_o),
        .sched_instr_o  (sched_instr_o),
        .sched_rs1_o    (sched_rs1_o),
        .sched_rs2_o    (sched_rs2_o),
        .sched_vld_o    (sched_vld_o),
        .sched_rdy_i    (sched_rdy_i),
        .vu_idle_i      (vu_idle_i),
        .flush_i        (flush_i),
        .count_o        (count_o),
        .empty_o        (empty_o)
    );

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic        rdy;
        logic        idle;
        logic        flush;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [2:0]  e_cnt;
        logic        e_stall;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] arith(input int k);
        return 32'h0221_0057 | (32'(k) << 7);
    endfunction

    function automatic logic [31:0] rs1_of(input logic [31:0] i);
        return i ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] rs2_of(input logic [31:0] i);
        return ~i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic [31:0] instr, input logic rdy,
                       input logic idle, input logic flush, input logic e_vld,
                       input logic [31:0] e_instr, input logic [2:0] e_cnt,
                       input logic e_stall, input logic e_empty);
        vec_t v;
        v.vld = vld; v.instr = instr; v.rdy = rdy; v.idle = idle; v.flush = flush;
        v.e_vld = e_vld; v.e_instr = e_instr; v.e_cnt = e_cnt;
        v.e_stall = e_stall; v.e_empty = e_empty;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic vld, input logic [31:0] instr, input logic rdy,
                         input logic idle, input logic flush);
        @(negedge clk);
        instr_vld_i    = vld;
        vector_instr_i = instr;
        rs1_i          = rs1_of(instr);
        rs2_i          = rs2_of(instr);
        sched_rdy_i    = rdy;
        vu_idle_i      = idle;
        flush_i        = flush;
        #1;
    endtask

    task automatic chk_head(input string tag, input logic e_vld, input logic [31:0] e_instr);
        chk({tag, ".vld"},   32'(sched_vld_o),   32'(e_vld));
        chk({tag, ".instr"}, sched_instr_o, e_vld ? e_instr : 32'h0);
        chk({tag, ".rs1"},   sched_rs1_o,   e_vld ? rs1_of(e_instr) : 32'h0);
        chk({tag, ".rs2"},   sched_rs2_o,   e_vld ? rs2_of(e_instr) : 32'h0);
    endtask

    task automatic chk_occ(input string tag, input logic [2:0] e_cnt,
                           input logic e_stall, input logic e_empty);
        chk({tag, ".count"}, 32'(count_o),        32'(e_cnt));
        chk({tag, ".stall"}, 32'(vector_stall_o), 32'(e_stall));
        chk({tag, ".empty"}, 32'(empty_o),        32'(e_empty));
    endtask

    initial begin
        logic [31:0] model[$];
        logic [31:0] stream_in;
        int sent, recvd, cyc;
        logic m_push, m_pop;

        rst = 1'b1; instr_vld_i = 1'b0; vector_instr_i = '0; rs1_i = '0; rs2_i = '0;
        sched_rdy_i = 1'b0; vu_idle_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state, fill to full with held 5th push, drain in order
        add(0, 0,        0, 1, 0,  0, 0,        0, 0, 1);
        add(1, arith(1), 0, 1, 0,  0, 0,        0, 0, 1);
        add(1, arith(2), 0, 1, 0,  1, arith(1), 1, 0, 0);
        add(1, arith(3), 0, 1, 0,  1, arith(1), 2, 0, 0);
        add(1, arith(4), 0, 1, 0,  1, arith(1), 3, 0, 0);
        add(1, arith(5), 0, 1, 0,  1, arith(1), 4, 1, 0);
        add(1, arith(5), 1, 1, 0,  1, arith(1), 4, 1, 0);
        add(0, 0,        1, 1, 0,  1, arith(2), 3, 0, 0);
        add(0, 0,        1, 1, 0,  1, arith(3), 2, 0, 0);
        add(0, 0,        1, 1, 0,  1, arith(4), 1, 0, 0);
        add(0, 0,        1, 1, 0,  0, 0,        0, 0, 1);
        // config fence: vsetvli then vadd, held while unit busy
        add(1, CFG,      1, 0, 0,  0, 0,        0, 0, 1);
        add(1, arith(6), 1, 0, 0,  0, 0,        1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0,  0, 0, 2, 0, 0);
        add(0, 0,        1, 1, 0,  1, CFG,      2, 0, 0);
        add(0, 0,        1, 0, 0,  1, arith(6), 1, 0, 0);
        add(0, 0,        1, 0, 0,  0, 0,        0, 0, 1);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].vld, vecs[i].instr, vecs[i].rdy, vecs[i].idle, vecs[i].flush);
            chk_head(tag, vecs[i].e_vld, vecs[i].e_instr);
            chk_occ(tag, vecs[i].e_cnt, vecs[i].e_stall, vecs[i].e_empty);
        end

        // streaming: push every cycle with scheduler ready; occupancy stays at 1
        for (int i = 0; i < 8; i++) begin
            drive(1, arith(16 + i), 1, 1, 0);
            if (i == 0) begin
                chk_head("stream0", 0, 0);
                chk_occ("stream0", 0, 0, 1);
            end else begin
                chk_head($sformatf("stream%0d", i), 1, arith(16 + i - 1));
                chk_occ($sformatf("stream%0d", i), 1, 0, 0);
            end
        end
        drive(0, 0, 1, 1, 0);
        chk_head("stream_last", 1, arith(23));
        drive(0, 0, 1, 1, 0);
        chk_occ("stream_end", 0, 0, 1);

        // wrap: 11 entries with random valid/ready against a queue model
        sent = 0; recvd = 0; cyc = 0;
        while (recvd < 11 && cyc < 400) begin
            stream_in = arith(0) ^ (32'(sent + 1) << 20);
            drive((sent < 11) && ($urandom_range(0, 2) != 0), stream_in,
                  $urandom_range(0, 1) == 1, 1, 0);
            chk({"wrap.count"}, 32'(count_o), 32'(model.size()));
            m_push = instr_vld_i && (model.size() < 4);
            m_pop  = (model.size() > 0) && sched_rdy_i;
            if (model.size() > 0) chk_head($sformatf("wrap%0d", recvd), 1, model[0]);
            else                  chk_head("wrap_empty", 0, 0);
            if (m_pop) begin
                void'(model.pop_front());
                recvd++;
            end
            if (m_push) begin
                model.push_back(stream_in);
                sent++;
            end
            cyc++;
        end
        chk("wrap.done", 32'(recvd), 32'd11);

        // flush at count=3 with a concurrent push; pushed entry must not appear
        drive(1, arith(1), 0, 1, 0);
        drive(1, arith(2), 0, 1, 0);
        drive(1, arith(3), 0, 1, 0);
        drive(1, arith(9), 0, 1, 1);
        chk_occ("pre_flush", 3, 0, 0);
        drive(0, 0, 1, 1, 0);
        chk_head("post_flush", 0, 0);
        chk_occ("post_flush", 0, 0, 1);
        drive(1, arith(10), 1, 1, 0);
        chk_occ("flush_idle", 0, 0, 1);
        drive(0, 0, 1, 1, 0);
        chk_head("after_flush_push", 1, arith(10));

        // reset mid-operation clears queue like a flush
        drive(1, arith(11), 0, 1, 0);
        drive(1, arith(12), 0, 1, 0);
        @(negedge clk);
        rst = 1'b1; instr_vld_i = 1'b1; vector_instr_i = arith(13);
        drive(0, 0, 0, 1, 0);
        rst = 1'b0;
        chk_head("mid_rst", 0, 0);
        chk_occ("mid_rst", 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
